// File: rtl/proc_mem_pkg.sv
// Shared types for the TinyRV1 memory responder: bring-up FSM states and
// the data-request type encoding used by the processor control unit.
package proc_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/proc_mem_array.sv
// Word storage for proc_mem: two combinational read ports (fetch and data)
// and one write port that commits at the clock edge.
module proc_mem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [2**AW];

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/proc_mem.sv
// TinyRV1 memory responder with clear/load/run bring-up sequencing.
// Optional PROC_MEM_BOUNDS_CHECK_EN rejects misaligned or out-of-range accesses.
module proc_mem
  import proc_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_data,
  input  logic        load_val,
  output logic        load_rdy,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        proc_rst,
  output logic        err
);

  localparam logic [AW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] iidx;
  logic [AW-1:0] didx;
  logic          run;
  logic          i_fault;
  logic          d_fault;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   irdata;
  logic [31:0]   drdata;

  assign iidx = imemreq_addr[AW+1:2];
  assign didx = dmemreq_addr[AW+1:2];
  assign run  = ~rst & (state == RUN);

`ifdef PROC_MEM_BOUNDS_CHECK_EN
  logic err_q;

  assign i_fault = imemreq_val &
                   ((imemreq_addr[1:0] != 2'b00) | (imemreq_addr[31:AW+2] != '0));
  assign d_fault = dmemreq_val &
                   ((dmemreq_addr[1:0] != 2'b00) | (dmemreq_addr[31:AW+2] != '0));

  // Sticky until reset; only processor traffic in RUN can raise it.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (run & (i_fault | d_fault)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_addr_bits;

  assign i_fault          = 1'b0;
  assign d_fault          = 1'b0;
  assign err              = 1'b0;
  assign unused_addr_bits = ^{imemreq_addr[31:AW+2], imemreq_addr[1:0],
                              dmemreq_addr[31:AW+2], dmemreq_addr[1:0]};
`endif

  // Each state owns the single write port, so the mux never has to arbitrate.
  always_comb begin
    wen   = 1'b0;
    waddr = cnt;
    wdata = '0;
    if (!rst) begin
      unique case (state)
        CLEAR: wen = 1'b1;
        LOAD: begin
          wen   = load_val;
          wdata = load_data;
        end
        RUN: begin
          wen   = dmemreq_val & (dmemreq_type == MEM_WRITE) & ~d_fault;
          waddr = didx;
          wdata = dmemreq_wdata;
        end
        default: wen = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (load_val) begin
            cnt <= cnt + 1'b1;
            if (load_last || (cnt == CNT_MAX)) begin
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: state <= RUN;
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Reset must hold the processor in the same cycle it is asserted.
  assign proc_rst = rst | (state != RUN);
  assign load_rdy = ~rst & (state == LOAD);

  assign imemresp_data = (run & imemreq_val & ~i_fault) ? irdata : '0;
  assign dmemresp_data = (run & dmemreq_val & (dmemreq_type == MEM_READ) & ~d_fault)
                         ? drdata : '0;

  proc_mem_array #(.AW(AW)) u_array (
    .clk     (clk),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (iidx),
    .rdata_a (irdata),
    .raddr_b (didx),
    .rdata_b (drdata)
  );

endmodule

// File: tb/tb_proc_mem.sv
// Directed bench for proc_mem (AW=4) with a spec-level memory model checked
// every cycle plus literal expectations; honours PROC_MEM_BOUNDS_CHECK_EN.
module tb_proc_mem;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemreq_val = 1'b0;
  logic [31:0] imemreq_addr = '0;
  logic [31:0] imemresp_data;
  logic        dmemreq_val = 1'b0;
  logic        dmemreq_type = 1'b0;
  logic [31:0] dmemreq_addr = '0;
  logic [31:0] dmemreq_wdata = '0;
  logic [31:0] dmemresp_data;
  logic        load_val = 1'b0;
  logic        load_rdy;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        proc_rst;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = clearing, 1 = loading, 2 = running.
  int          m_phase = 0;
  int          m_clr = 0;
  int          m_ptr = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  proc_mem #(.AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_addr  (imemreq_addr),
    .imemresp_data (imemresp_data),
    .dmemreq_val   (dmemreq_val),
    .dmemreq_type  (dmemreq_type),
    .dmemreq_addr  (dmemreq_addr),
    .dmemreq_wdata (dmemreq_wdata),
    .dmemresp_data (dmemresp_data),
    .load_val      (load_val),
    .load_rdy      (load_rdy),
    .load_data     (load_data),
    .load_last     (load_last),
    .proc_rst      (proc_rst),
    .err           (err)
  );

  function automatic bit faulty(input logic [31:0] a);
`ifdef PROC_MEM_BOUNDS_CHECK_EN
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dt, input logic [31:0] da,
                               input logic [31:0] dw, input logic lv,
                               input logic [31:0] ld, input logic ll);
    @(negedge clk);
    rst = r; imemreq_val = iv; imemreq_addr = ia;
    dmemreq_val = dv; dmemreq_type = dt; dmemreq_addr = da; dmemreq_wdata = dw;
    load_val = lv; load_data = ld; load_last = ll;
    #2;
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 0, '0, 0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic loadWord(input logic [31:0] d, input logic l);
    applyStimulus(0, 0, '0, 0, 0, '0, '0, 1, d, l);
  endtask

  task automatic access(input logic iv, input logic [31:0] ia, input logic dv,
                        input logic dt, input logic [31:0] da, input logic [31:0] dw);
    applyStimulus(0, iv, ia, dv, dt, da, dw, 0, '0, 0);
  endtask

  // Model advances at each rising edge from the inputs held since the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_clr = 0; m_ptr = 0; m_err = 1'b0;
      end else if (m_phase == 0) begin
        m_mem[m_clr] = '0;
        m_clr++;
        if (m_clr == DEPTH) begin m_phase = 1; m_ptr = 0; end
      end else if (m_phase == 1) begin
        if (load_val) begin
          m_mem[m_ptr] = load_data;
          m_ptr++;
          if (load_last || m_ptr == DEPTH) m_phase = 2;
        end
      end else begin
        if (imemreq_val && faulty(imemreq_addr)) m_err = 1'b1;
        if (dmemreq_val && faulty(dmemreq_addr)) m_err = 1'b1;
        if (dmemreq_val && dmemreq_type && !faulty(dmemreq_addr))
          m_mem[widx(dmemreq_addr)] = dmemreq_wdata;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid low phase.
  initial begin
    logic [31:0] e_i, e_d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      e_i = '0;
      e_d = '0;
      if (!rst && m_phase == 2) begin
        if (imemreq_val && !faulty(imemreq_addr)) e_i = m_mem[widx(imemreq_addr)];
        if (dmemreq_val && !dmemreq_type && !faulty(dmemreq_addr))
          e_d = m_mem[widx(dmemreq_addr)];
      end
      checkOutput("model_proc_rst", {31'd0, proc_rst}, {31'd0, rst || m_phase != 2});
      checkOutput("model_load_rdy", {31'd0, load_rdy}, {31'd0, !rst && m_phase == 1});
      checkOutput("model_imemresp", imemresp_data, e_i);
      checkOutput("model_dmemresp", dmemresp_data, e_d);
      checkOutput("model_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  initial begin
    idle(1);
    idle(1);
    checkOutput("reset_proc_rst", {31'd0, proc_rst}, 32'd1);

    for (int k = 1; k <= 16; k++) begin
      idle(0);
      checkOutput("clear_load_rdy", {31'd0, load_rdy}, 32'd0);
      checkOutput("clear_proc_rst", {31'd0, proc_rst}, 32'd1);
    end

    loadWord(32'h0010_0093, 0);
    checkOutput("cycle17_load_rdy", {31'd0, load_rdy}, 32'd1);
    loadWord(32'h0020_0113, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 32'h0, 1, 0, 32'h4, '0, 0, 32'hFFFF_FFFF, 0);
      checkOutput("stall_load_rdy", {31'd0, load_rdy}, 32'd1);
      checkOutput("stall_imem_zero", imemresp_data, 32'd0);
    end
    loadWord(32'h0020_81b3, 1);
    checkOutput("last_proc_rst", {31'd0, proc_rst}, 32'd1);

    access(1, 32'h0, 0, 0, '0, '0);
    checkOutput("run_proc_rst", {31'd0, proc_rst}, 32'd0);
    checkOutput("fetch_0x0", imemresp_data, 32'h0010_0093);
    access(1, 32'h4, 0, 0, '0, '0);
    checkOutput("fetch_0x4", imemresp_data, 32'h0020_0113);
    access(1, 32'h8, 1, 0, 32'h8, '0);
    checkOutput("fetch_0x8", imemresp_data, 32'h0020_81b3);
    checkOutput("lw_0x8", dmemresp_data, 32'h0020_81b3);
    access(1, 32'hC, 0, 0, '0, '0);
    checkOutput("fetch_0xC", imemresp_data, 32'd0);

    access(1, 32'h10, 1, 1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("sw_cycle_dmem", dmemresp_data, 32'd0);
    checkOutput("sw_cycle_imem_old", imemresp_data, 32'd0);
    access(1, 32'h10, 1, 0, 32'h10, '0);
    checkOutput("lw_0x10", dmemresp_data, 32'hDEAD_BEEF);
    checkOutput("fetch_0x10", imemresp_data, 32'hDEAD_BEEF);
    access(0, '0, 1, 1, 32'h14, 32'h1234_5678);

    applyStimulus(0, 1, 32'h0, 0, 0, '0, '0, 1, 32'hFFFF_FFFF, 1);
    checkOutput("run_load_rdy", {31'd0, load_rdy}, 32'd0);
    checkOutput("loader_dropped", imemresp_data, 32'h0010_0093);

    access(0, '0, 1, 1, 32'h44, 32'hA5A5_A5A5);
    access(1, 32'h4, 1, 0, 32'h2, '0);
`ifdef PROC_MEM_BOUNDS_CHECK_EN
    checkOutput("oob_sw_suppressed", imemresp_data, 32'h0020_0113);
    checkOutput("misaligned_lw_zero", dmemresp_data, 32'd0);
    checkOutput("err_set", {31'd0, err}, 32'd1);
    access(0, '0, 0, 0, '0, '0);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
`else
    checkOutput("alias_sw_writes", imemresp_data, 32'hA5A5_A5A5);
    checkOutput("misaligned_lw_alias", dmemresp_data, 32'h0010_0093);
    checkOutput("err_tied_low", {31'd0, err}, 32'd0);
`endif

    idle(1);
    checkOutput("rst_cycle_proc_rst", {31'd0, proc_rst}, 32'd1);
    idle(1);
    checkOutput("rst_next_proc_rst", {31'd0, proc_rst}, 32'd1);
    checkOutput("rst_err_clear", {31'd0, err}, 32'd0);
    for (int k = 0; k < 16; k++) idle(0);
    loadWord(32'hCAFE_F00D, 1);
    access(1, 32'h10, 1, 0, 32'h14, '0);
    checkOutput("reload_0x10_cleared", imemresp_data, 32'd0);
    checkOutput("reload_0x14_cleared", dmemresp_data, 32'd0);
    access(1, 32'h0, 1, 0, 32'h4, '0);
    checkOutput("reload_word0", imemresp_data, 32'hCAFE_F00D);
    checkOutput("reload_0x4_cleared", dmemresp_data, 32'd0);

    idle(1);
    idle(1);
    for (int k = 0; k < 16; k++) idle(0);
    for (int i = 0; i < 20; i++) begin
      loadWord(32'h1000 + i, 0);
      if (i < 16) checkOutput("stream_load_rdy", {31'd0, load_rdy}, 32'd1);
      if (i == 16) checkOutput("overflow_run", {31'd0, proc_rst}, 32'd0);
    end
    access(1, 32'h0, 1, 0, 32'h3C, '0);
    checkOutput("overflow_word0", imemresp_data, 32'h1000);
    checkOutput("overflow_word15", dmemresp_data, 32'h100F);

    idle(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_mem.md
Name: proc_mem

Overview:
- Memory responder for the TinyRV1 pipelined processor: services fetch requests (imemreq) and load/store requests (dmemreq) issued by the processor's control/datapath.
- Word-organised storage. Reads are combinational, returning data in the same cycle as the request, as the F and M stages require. Writes commit at the clock edge.
- Owns program bring-up: after reset it zeroes the array, accepts a program image over a valid/ready loader stream, then releases the processor by deasserting proc_rst.

Parameters:
- AW, 8, word-address width; depth = 2**AW words (default 1 KiB).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imemreq_val  in  1  fetch request valid
- imemreq_addr  in  32  fetch byte address
- imemresp_data  out  32  fetch data, combinational
- dmemreq_val  in  1  data request valid
- dmemreq_type  in  1  0 = read (LW), 1 = write (SW)
- dmemreq_addr  in  32  data byte address
- dmemreq_wdata  in  32  store data
- dmemresp_data  out  32  load data, combinational
- load_val  in  1  loader word valid
- load_rdy  out  1  loader ready
- load_data  in  32  loader word
- load_last  in  1  marks final loader word
- proc_rst  out  1  processor reset hold, active-high
- err  out  1  sticky access error (see Optional Feature)

Behaviour:
- Word index = addr[AW+1:2]. addr[1:0] is ignored. Upper bits alias unless the optional feature is enabled.
- FSM states: CLEAR, LOAD, RUN. Counter cnt is AW bits wide.
- Reset (any cycle, including mid-LOAD or mid-RUN): state <= CLEAR, cnt <= 0, err <= 0.
- Outputs during the reset cycle and in CLEAR: proc_rst = 1, load_rdy = 0, imemresp_data = 0, dmemresp_data = 0.
- Array contents are not reset directly; CLEAR rewrites them.
- CLEAR:
  - Each cycle writes 0 to word cnt, then cnt++.
  - When cnt == 2**AW-1 is written: cnt <= 0, next state LOAD.
  - Duration is exactly 2**AW cycles.
- LOAD:
  - load_rdy = 1, proc_rst = 1.
  - On load_val & load_rdy: mem[cnt] <= load_data, cnt++.
  - If load_last, or cnt == 2**AW-1, the next state is RUN after that write. The accepting cycle still writes.
  - load_val low: no change; waits indefinitely.
  - The processor ports are ignored and both resp buses are 0.
- RUN:
  - proc_rst = 0, load_rdy = 0.
  - load_val is ignored; loader words are dropped.
  - imemresp_data = mem[imem index] when imemreq_val, else 0.
  - dmemresp_data = mem[dmem index] when dmemreq_val & ~dmemreq_type, else 0.
  - Write: dmemreq_val & dmemreq_type writes dmemreq_wdata at the edge.
  - RUN persists until rst.
- Simultaneous write and read, same word, same cycle: both response ports return the old value; the new value is visible from the next cycle.
- The imem port never writes. Only one write source is active per state, so no write-port conflicts occur.
- Latency: read 0 cycles (combinational), write 1 edge.
- proc_rst falls in the first RUN cycle. The processor therefore samples reset low at the edge after the final load write.

Optional Feature:
- Macro: PROC_MEM_BOUNDS_CHECK_EN.
- Enabled, in RUN: an access with val = 1 is faulty if addr[1:0] != 0 or addr[31:AW+2] != 0.
  - Faulty write is suppressed.
  - Faulty read returns 0.
  - err <= 1 at the next edge and stays set until rst.
  - Either port can raise err.
- Disabled: err is tied 0; addresses alias as above; misaligned low bits are dropped silently.

Decomposition:
- Shared package holds:
  - state enum (CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2)
  - dmemreq_type constants MEM_READ = 0, MEM_WRITE = 1 (matching the processor control encoding)
- One sub-module: proc_mem_array, a 2**AW x 32 array with two combinational read ports and one synchronous write port (wen, waddr, wdata).
- The FSM and write-source mux live in the top module.

Test Plan:
- Reset then idle with AW=4:
  - proc_rst = 1 and load_rdy = 0 for 16 cycles.
  - load_rdy = 1 on cycle 17.
  - proc_rst stays 1 throughout.
- Load three words 0x00100093, 0x00200113, 0x002081b3 (last on the third), then run:
  - proc_rst = 0 the cycle after the third handshake.
  - imemreq_addr 0x0, 0x4, 0x8 return those words.
  - Address 0xC returns 0 (cleared).
- In RUN, same cycle: SW 0xDEADBEEF to 0x10 and LW from 0x10:
  - dmemresp_data = 0 that cycle.
  - LW the next cycle returns 0xDEADBEEF.
  - imem read of 0x10 also returns 0xDEADBEEF.
- Loader stall and overflow:
  - Hold load_val low 5 cycles mid-load: cnt is unchanged.
  - With AW=4, stream 20 words with no load_last: only 16 are written; RUN is entered after word 16; words 17-20 are not accepted.
- rst asserted mid-RUN after stores:
  - Returns to CLEAR; proc_rst = 1 the next cycle.
  - After reload of a single last word, previously stored locations read 0.
- With PROC_MEM_BOUNDS_CHECK_EN and AW=4:
  - SW to 0x44 (out of range, aliases to index 1): no write; mem[1] is unchanged; err = 1 next cycle.
  - LW 0x2 (misaligned) returns 0; err stays 1.
  - Without the macro, the same SW writes mem[1] and err = 0.
